uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the OTTER MCU I/O space. It converts the board `RX` line (8 data bits, no parity, 1 stop bit, LSB first) into bytes held for the processor. It is the receiving counterpart of the wrapper's `Tx` path, and its outputs feed the wrapper's memory-mapped input mux. Bytes are presented through a one-deep holding register with a valid/read handshake, plus sticky framing-error and overrun flags.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD`, with integer truncation (434 at the defaults). `HALF_BIT = CLKS_PER_BIT / 2` (217).

- `CLK` input 1: system clock. All state is on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `RX` input 1: serial line, idles high. It is asynchronous to `CLK`.
- `RD` input 1: single-cycle pulse that consumes the held byte.
- `CLR` input 1: single-cycle pulse that clears `FRAME_ERR` and `OVERRUN`.
- `DATA` output 8: the held byte. It is stable while `VALID` is 1.
- `VALID` output 1: the holding register is full.
- `BUSY` output 1: a frame is in progress (state is not IDLE).
- `FRAME_ERR` output 1: sticky flag; a stop bit was sampled low.
- `OVERRUN` output 1: sticky flag; a byte was dropped because the register was full.

## Operation
- **Synchronizer.** `RX` passes through two flops (reset value 1) to produce `rx_s`. Every decision uses `rx_s`.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE.** Move to START when `rx_s` is 0. Clear the bit counter and the baud counter.
- **START.** Count `HALF_BIT` cycles, then sample `rx_s`.
  - 0: go to DATA and reload the baud counter.
  - 1: the start was a glitch; return to IDLE. No flags change.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After the 8th sample, go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - 1: the frame is good. Do the load step below, then go to IDLE.
  - 0: set `FRAME_ERR`. Discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` is 1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.
- **Load step (good stop bit), first matching case applies:**
  - `VALID`=0: load `DATA` and set `VALID`.
  - `VALID`=1 with `RD`=1 in the same cycle: load the new byte and keep `VALID`=1.
  - `VALID`=1 with `RD`=0: keep the old `DATA`, drop the new byte, set `OVERRUN`.
- **Read.** `RD` with `VALID`=1 clears `VALID` on the next edge. `RD` with `VALID`=0 is ignored. `DATA` keeps its last value after a read.
- **Clear.** `CLR` clears both sticky flags. If `CLR` arrives in the same cycle as a new flag event, the set wins.
- **Reset.**
  - Outputs: `DATA`=0x00, `VALID`=0, `BUSY`=0, `FRAME_ERR`=0, `OVERRUN`=0.
  - Internal: FSM in IDLE, synchronizer flops at 1.
  - A reset in mid-frame abandons the frame. Reception restarts on the next falling edge seen after reset is released.

## Timing
- Latency from an `RX` falling edge to `BUSY`=1 is 3 `CLK` edges (2 synchronizer edges plus the IDLE→START transition).
- Each data bit is sampled `HALF_BIT + k*CLKS_PER_BIT` cycles after start detection, for k = 1..8. The stop bit is sampled at k = 9.
- `VALID` rises on the edge after the stop sample. At the defaults this is about 9.5 bit times (≈82.5 µs) after the start edge.
- `BUSY` falls on that same edge.
- The block accepts a new start edge in the IDLE cycle immediately after STOP, so frames sent back-to-back with 1 stop bit are received.
- Baud-rate tolerance at the defaults is about ±4%. This follows from centre sampling with the truncated `CLKS_PER_BIT`.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `DATA_BITS` = 8.
  - a function that computes `CLKS_PER_BIT` from `CLK_FREQ` and `BAUD`. The transmitter reuses it.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a parameterised reset value. The top level instantiates it with reset value 1.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit counter is 3 bits.

## Test plan
The bench drives `RX` at 8680 ns per bit, which is 434 × 20 ns at a 50 MHz clock.
- **Single byte.** Send 0xA5 with a good stop bit → `VALID` rises after about 82.5 µs with `DATA`=0xA5; `FRAME_ERR`=0 and `OVERRUN`=0. Pulse `RD` → `VALID`=0 on the next edge.
- **Glitch.** Drive a 2 µs low pulse on an idle line → `BUSY` returns to 0 after the half-bit check; `VALID`, `FRAME_ERR` and `OVERRUN` all stay 0.
- **Framing error.** Send 0x3C with the stop bit low, hold the line low for 3 more bit times, then release it → `FRAME_ERR`=1, `VALID`=0, and `BUSY` stays 1 until the line returns high. A following 0x55 is then received correctly.
- **Overrun.** Send 0x11, then 0x22 back-to-back with no `RD` → `DATA`=0x11 and `OVERRUN`=1. `RD` then `CLR` → `VALID`=0 and `OVERRUN`=0.
- **Read and load together.** Hold 0x11, then assert `RD` in exactly the cycle the 0x22 stop bit is accepted → `DATA`=0x22, `VALID` stays 1, `OVERRUN`=0.
- **Reset in mid-frame.** Assert `RST` during bit 4 of 0xF0 → all outputs 0 immediately. After release, a fresh 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Truncating divide; the transmitter uses the same divisor so both ends agree.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-host bundle: serial line and read/clear strobes in, held byte and status out.
interface uart_rx_if;

  logic                            RX;
  logic                            RD;
  logic                            CLR;
  logic [uart_pkg::DATA_BITS-1:0]  DATA;
  logic                            VALID;
  logic                            BUSY;
  logic                            FRAME_ERR;
  logic                            OVERRUN;

  modport master (
    output RX, RD, CLR,
    input  DATA, VALID, BUSY, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  RX, RD, CLR,
    output DATA, VALID, BUSY, FRAME_ERR, OVERRUN
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-deep holding register; VALID ~9.5 bit times after the start edge.
// No backpressure on the line: a byte arriving while the register is full is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [2:0]    BITS_LAST = 3'(DATA_BITS - 1);

  uart_rx_state_t         state, state_nxt;
  logic                   rx_s;
  logic [CW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, frame_err_q, overrun_q;

  logic half_hit, bit_hit;
  logic busy, baud_clr, bit_clr, shift_en, stop_good, stop_bad;
  logic load;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (bus.RX),
    .q   (rx_s)
  );

  assign half_hit = (baud_cnt == HALF_LAST);
  assign bit_hit  = (baud_cnt == BIT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_hit && bit_cnt == BITS_LAST) state_nxt = STOP;
      STOP:      if (bit_hit) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    baud_clr  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        baud_clr = 1'b1;
        bit_clr  = 1'b1;
      end
      START:     baud_clr = half_hit;
      DATA: begin
        baud_clr = bit_hit;
        shift_en = bit_hit;
      end
      STOP: begin
        stop_good = bit_hit && rx_s;
        stop_bad  = bit_hit && !rx_s;
      end
      WAIT_HIGH: baud_clr = 1'b1;
      default:   baud_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= baud_clr ? '0 : baud_cnt + CW'(1);
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)      shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  // A read in the same cycle as a good stop bit frees the slot for the new byte.
  assign load = stop_good && (!valid_q || bus.RD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (bus.RD) begin
        valid_q <= 1'b0;
      end
      if (stop_bad)     frame_err_q <= 1'b1;
      else if (bus.CLR) frame_err_q <= 1'b0;
      if (stop_good && valid_q && !bus.RD) overrun_q <= 1'b1;
      else if (bus.CLR)                    overrun_q <= 1'b0;
    end
  end

  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.BUSY      = busy;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 50 MHz clock, 434 clocks per bit on the RX line.
module tb_uart_rx;

  localparam int CPB = 434;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.RX = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic pulse_rd();
    bus.RD = 1'b1;
    @(negedge clk);
    bus.RD = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.CLR = 1'b1;
    @(negedge clk);
    bus.CLR = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.RX  = 1'b1;
    bus.RD  = 1'b0;
    bus.CLR = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(bus.DATA), 32'h00);
    check("rst_valid", 32'(bus.VALID), 0);
    check("rst_busy",  32'(bus.BUSY), 0);
    check("rst_ferr",  32'(bus.FRAME_ERR), 0);
    check("rst_ovr",   32'(bus.OVERRUN), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte with start-detect latency and VALID timing
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1 check("busy_after_2", 32'(bus.BUSY), 0);
        @(posedge clk);
        #1 check("busy_after_3", 32'(bus.BUSY), 1);
        n = 3;
        while (!bus.VALID && n < 6000) begin
          @(posedge clk);
          #1 n++;
        end
        check("valid_latency_window", 32'(n >= 4120 && n <= 4135), 1);
      end
    join
    check("a5_valid", 32'(bus.VALID), 1);
    check("a5_data",  32'(bus.DATA), 32'hA5);
    check("a5_ferr",  32'(bus.FRAME_ERR), 0);
    check("a5_ovr",   32'(bus.OVERRUN), 0);
    check("a5_busy",  32'(bus.BUSY), 0);
    pulse_rd();
    check("a5_rd_valid", 32'(bus.VALID), 0);
    check("a5_rd_data",  32'(bus.DATA), 32'hA5);

    // 2 us glitch on an idle line
    bus.RX = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_hi", 32'(bus.BUSY), 1);
    repeat (50) @(negedge clk);
    bus.RX = 1'b1;
    repeat (250) @(negedge clk);
    check("glitch_busy_lo", 32'(bus.BUSY), 0);
    check("glitch_valid",   32'(bus.VALID), 0);
    check("glitch_ferr",    32'(bus.FRAME_ERR), 0);
    check("glitch_ovr",     32'(bus.OVERRUN), 0);

    // Framing error followed by a break, then a good byte
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("fe_ferr",  32'(bus.FRAME_ERR), 1);
    check("fe_valid", 32'(bus.VALID), 0);
    check("fe_busy",  32'(bus.BUSY), 1);
    bus.RX = 1'b1;
    repeat (5) @(negedge clk);
    check("fe_release_busy", 32'(bus.BUSY), 0);
    send_frame(8'h55, 1'b1);
    check("fe_next_valid", 32'(bus.VALID), 1);
    check("fe_next_data",  32'(bus.DATA), 32'h55);
    check("fe_sticky",     32'(bus.FRAME_ERR), 1);
    pulse_clr();
    check("fe_cleared", 32'(bus.FRAME_ERR), 0);
    pulse_rd();

    // Overrun: two back-to-back bytes, no read
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_data",  32'(bus.DATA), 32'h11);
    check("ovr_valid", 32'(bus.VALID), 1);
    check("ovr_flag",  32'(bus.OVERRUN), 1);
    pulse_rd();
    pulse_clr();
    check("ovr_rd_valid", 32'(bus.VALID), 0);
    check("ovr_clr_flag", 32'(bus.OVERRUN), 0);

    // Read coincident with the stop-bit acceptance of the next byte
    send_frame(8'h11, 1'b1);
    check("rl_pre_data", 32'(bus.DATA), 32'h11);
    fork
      send_frame(8'h22, 1'b1);
      begin
        n = 0;
        while (!bus.BUSY && n < 10) begin
          @(posedge clk);
          #1 n++;
        end
        check("rl_busy_rise", 32'(n), 3);
        repeat (4122) @(posedge clk);
        @(negedge clk);
        bus.RD = 1'b1;
        check("rl_busy_before_stop", 32'(bus.BUSY), 1);
        @(posedge clk);
        #1 check("rl_busy_after_stop", 32'(bus.BUSY), 0);
        @(negedge clk);
        bus.RD = 1'b0;
      end
    join
    check("rl_data",  32'(bus.DATA), 32'h22);
    check("rl_valid", 32'(bus.VALID), 1);
    check("rl_ovr",   32'(bus.OVERRUN), 0);

    // Reset during bit 4 of 0xF0, then a fresh byte
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * CPB + 200) @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check("mid_rst_data",  32'(bus.DATA), 32'h00);
        check("mid_rst_valid", 32'(bus.VALID), 0);
        check("mid_rst_busy",  32'(bus.BUSY), 0);
        check("mid_rst_ferr",  32'(bus.FRAME_ERR), 0);
        check("mid_rst_ovr",   32'(bus.OVERRUN), 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("post_rst_idle_valid", 32'(bus.VALID), 0);
    send_frame(8'h81, 1'b1);
    check("post_rst_valid", 32'(bus.VALID), 1);
    check("post_rst_data",  32'(bus.DATA), 32'h81);
    check("post_rst_ferr",  32'(bus.FRAME_ERR), 0);
    check("post_rst_ovr",   32'(bus.OVERRUN), 0);
    check("post_rst_busy",  32'(bus.BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
